// File: rtl/dma_line_fsm.sv
// Cache-line DMA sequencer: splits host FIFO lines into memory word writes and
// packs memory word reads back into lines for the host write FIFO.
module dma_line_fsm #(
  parameter int CL_SIZE_WIDTH = 512,
  parameter int WORD_SIZE     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     empty,
  input  logic [CL_SIZE_WIDTH-1:0] dma_rd_data,
  output logic                     host_rd_ready,
  input  logic                     full,
  output logic [CL_SIZE_WIDTH-1:0] line_buffer,
  output logic                     host_wr_ready,
  input  logic                     wr_ready,
  output logic                     DMAEn,
  output logic                     DMAWrEn,
  output logic [31:0]              DMAAddr,
  output logic [WORD_SIZE-1:0]     data_to_mem,
  input  logic [WORD_SIZE-1:0]     data_to_host,
  input  logic                     DMAValid
);

  localparam int WORDS = CL_SIZE_WIDTH / WORD_SIZE;
  localparam int CW    = $clog2(WORDS);
  localparam int IW    = CW + 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
  localparam logic [IW-1:0] ALL_ISSUED = IW'(WORDS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] POP    = 3'd1;
  localparam logic [2:0] WR_MEM = 3'd2;
  localparam logic [2:0] RD_MEM = 3'd3;
  localparam logic [2:0] PUSH   = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [CL_SIZE_WIDTH-1:0] sr_q, sr_d;
  logic [CL_SIZE_WIDTH-1:0] lb_q, lb_d;
  logic [CW-1:0]            wcnt_q, wcnt_d;
  logic [CW-1:0]            cap_q, cap_d;
  logic [IW-1:0]            iss_q, iss_d;
  logic [31:0]              wptr_q, wptr_d;
  logic [31:0]              rptr_q, rptr_d;
  logic [31:0]              addr_q, addr_d;
  logic [WORD_SIZE-1:0]     wdata_q, wdata_d;
  logic                     en_q, en_d;
  logic                     wren_q, wren_d;
  logic                     rd_rdy_q, rd_rdy_d;
  logic                     wr_rdy_q, wr_rdy_d;

  // Bus outputs are registered one cycle ahead: the edge that enters a state
  // already loads the first word/address that state presents.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    lb_d     = lb_q;
    wcnt_d   = wcnt_q;
    cap_d    = cap_q;
    iss_d    = iss_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    en_d     = 1'b0;
    wren_d   = 1'b0;
    rd_rdy_d = 1'b0;
    wr_rdy_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d  = POP;
          rd_rdy_d = 1'b1;
        end else if (wr_ready) begin
          state_d = RD_MEM;
          en_d    = 1'b1;
          addr_d  = rptr_q;
          rptr_d  = rptr_q + 32'd1;
          iss_d   = IW'(1);
          cap_d   = '0;
        end
      end
      POP: begin
        state_d = WR_MEM;
        wcnt_d  = '0;
        en_d    = 1'b1;
        wren_d  = 1'b1;
        addr_d  = wptr_q;
        wptr_d  = wptr_q + 32'd1;
        wdata_d = dma_rd_data[WORD_SIZE-1:0];
        sr_d    = dma_rd_data >> WORD_SIZE;
      end
      WR_MEM: begin
        if (wcnt_q == LAST_WORD) begin
          state_d = IDLE;
        end else begin
          wcnt_d  = wcnt_q + 1'b1;
          en_d    = 1'b1;
          wren_d  = 1'b1;
          addr_d  = wptr_q;
          wptr_d  = wptr_q + 32'd1;
          wdata_d = sr_q[WORD_SIZE-1:0];
          sr_d    = sr_q >> WORD_SIZE;
        end
      end
      RD_MEM: begin
        if (iss_q != ALL_ISSUED) begin
          en_d   = 1'b1;
          addr_d = rptr_q;
          rptr_d = rptr_q + 32'd1;
          iss_d  = iss_q + 1'b1;
        end
        if (DMAValid) begin
          for (int unsigned k = 0; k < WORDS; k++) begin
            if (cap_q == CW'(k)) lb_d[k*WORD_SIZE +: WORD_SIZE] = data_to_host;
          end
          cap_d = cap_q + 1'b1;
          if (cap_q == LAST_WORD) state_d = PUSH;
        end
      end
      PUSH: begin
        if (!full) begin
          wr_rdy_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      lb_q     <= '0;
      wcnt_q   <= '0;
      cap_q    <= '0;
      iss_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      en_q     <= 1'b0;
      wren_q   <= 1'b0;
      rd_rdy_q <= 1'b0;
      wr_rdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      lb_q     <= lb_d;
      wcnt_q   <= wcnt_d;
      cap_q    <= cap_d;
      iss_q    <= iss_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      en_q     <= en_d;
      wren_q   <= wren_d;
      rd_rdy_q <= rd_rdy_d;
      wr_rdy_q <= wr_rdy_d;
    end
  end

  assign host_rd_ready = rd_rdy_q;
  assign host_wr_ready = wr_rdy_q;
  assign line_buffer   = lb_q;
  assign DMAEn         = en_q;
  assign DMAWrEn       = wren_q;
  assign DMAAddr       = addr_q;
  assign data_to_mem   = wdata_q;

endmodule

// File: tb/tb_dma_line_fsm.sv
// Bench for dma_line_fsm: per-cycle expectations come from a transfer-level
// schedule model; host FIFOs and a 1-cycle-latency memory are modelled here.
module tb_dma_line_fsm;
  localparam int CL = 512;
  localparam int W  = 32;
  localparam int N  = CL / W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          empty = 1'b1;
  logic [CL-1:0] dma_rd_data = '0;
  logic          host_rd_ready;
  logic          full = 1'b0;
  logic [CL-1:0] line_buffer;
  logic          host_wr_ready;
  logic          wr_ready = 1'b0;
  logic          DMAEn;
  logic          DMAWrEn;
  logic [31:0]   DMAAddr;
  logic [W-1:0]  data_to_mem;
  logic [W-1:0]  data_to_host = '0;
  logic          DMAValid = 1'b0;

  dma_line_fsm #(.CL_SIZE_WIDTH(CL), .WORD_SIZE(W)) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .dma_rd_data(dma_rd_data),
    .host_rd_ready(host_rd_ready), .full(full), .line_buffer(line_buffer),
    .host_wr_ready(host_wr_ready), .wr_ready(wr_ready), .DMAEn(DMAEn),
    .DMAWrEn(DMAWrEn), .DMAAddr(DMAAddr), .data_to_mem(data_to_mem),
    .data_to_host(data_to_host), .DMAValid(DMAValid)
  );

  always #5 clk = ~clk;

  // One expected-output record per clock cycle; idle/is_push mark cycles whose
  // closing edge makes a decision.
  typedef struct {
    bit            idle;
    bit            is_push;
    bit            en;
    bit            wren;
    bit            rd;
    bit            wr;
    bit            chk_lb;
    logic [31:0]   addr;
    logic [W-1:0]  data;
    logic [CL-1:0] lb;
  } rec_t;

  rec_t          sched[$];
  logic [CL-1:0] fifo_q[$];
  logic [W-1:0]  mem[logic [31:0]];
  logic [W-1:0]  ref_mem[logic [31:0]];
  logic [W-1:0]  wlog[$];
  logic [31:0]   walog[$];
  logic [31:0]   ralog[$];
  logic [CL-1:0] plog[$];

  logic [31:0]   m_wptr, m_rptr, last_addr;
  logic [W-1:0]  last_wdata;
  logic [CL-1:0] last_lb;
  int            vectors = 0;
  int            errors = 0;
  bit            s_en, s_wren, s_rd, s_wr;
  logic [31:0]   s_addr;
  logic [W-1:0]  s_data;
  bit            pend = 1'b0;
  logic [W-1:0]  pend_data = '0;
  bit            knob_rstn = 1'b0;
  bit            knob_wr = 1'b0;
  bit            knob_full = 1'b0;

  task automatic chk(string name, logic [CL-1:0] act, logic [CL-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic rec_t blank();
    rec_t r;
    r.idle = 0; r.is_push = 0; r.en = 0; r.wren = 0;
    r.rd = 0; r.wr = 0; r.chk_lb = 0;
    r.addr = last_addr; r.data = last_wdata; r.lb = last_lb;
    return r;
  endfunction

  task automatic put(rec_t r);
    sched.push_back(r);
    last_addr  = r.addr;
    last_wdata = r.data;
  endtask

  task automatic model_reset();
    rec_t r;
    sched.delete();
    m_wptr = '0; m_rptr = '0; last_addr = '0; last_wdata = '0; last_lb = '0;
    r = blank(); r.idle = 1; r.chk_lb = 1;
    put(r);
  endtask

  task automatic model_decide(rec_t r);
    rec_t          n;
    logic [CL-1:0] line;
    logic [31:0]   a;
    if (r.idle) begin
      if (fifo_q.size() != 0) begin
        line = fifo_q[0];
        n = blank(); n.rd = 1; put(n);
        for (int i = 0; i < N; i++) begin
          n = blank(); n.en = 1; n.wren = 1;
          n.addr = m_wptr + 32'(i); n.data = line[i*W +: W];
          put(n);
        end
        m_wptr += 32'(N);
        n = blank(); n.idle = 1; n.chk_lb = 1; put(n);
      end else if (wr_ready) begin
        for (int i = 0; i < N; i++) begin
          a = m_rptr + 32'(i);
          n = blank(); n.en = 1; n.addr = a; put(n);
          line[i*W +: W] = ref_mem.exists(a) ? ref_mem[a] : '0;
        end
        n = blank(); put(n);
        m_rptr += 32'(N);
        last_lb = line;
        n = blank(); n.is_push = 1; n.chk_lb = 1; put(n);
      end else begin
        n = blank(); n.idle = 1; n.chk_lb = 1; put(n);
      end
    end else if (r.is_push) begin
      n = blank(); n.chk_lb = 1;
      if (full) n.is_push = 1;
      else begin n.idle = 1; n.wr = 1; end
      put(n);
    end
  endtask

  task automatic step();
    rec_t r;
    @(negedge clk);
    if (sched.size() == 0) begin
      vectors++; errors++;
      $display("FAIL sched: model has no expectation for this cycle");
      model_reset();
    end
    r = sched[0];
    chk("DMAEn", CL'(DMAEn), CL'(r.en));
    chk("DMAWrEn", CL'(DMAWrEn), CL'(r.wren));
    chk("host_rd_ready", CL'(host_rd_ready), CL'(r.rd));
    chk("host_wr_ready", CL'(host_wr_ready), CL'(r.wr));
    chk("DMAAddr", CL'(DMAAddr), CL'(r.addr));
    chk("data_to_mem", CL'(data_to_mem), CL'(r.data));
    if (r.chk_lb) chk("line_buffer", line_buffer, r.lb);
    s_en = DMAEn; s_wren = DMAWrEn; s_rd = host_rd_ready; s_wr = host_wr_ready;
    s_addr = DMAAddr; s_data = data_to_mem;
    if (s_en && s_wren) begin wlog.push_back(s_data); walog.push_back(s_addr); end
    if (s_en && !s_wren) ralog.push_back(s_addr);
    if (s_wr) plog.push_back(line_buffer);
    rst_n        = knob_rstn;
    empty        = (fifo_q.size() == 0);
    dma_rd_data  = empty ? '0 : fifo_q[0];
    wr_ready     = knob_wr;
    full         = knob_full;
    DMAValid     = pend;
    data_to_host = pend ? pend_data : W'($urandom());
    @(posedge clk);
    r = sched.pop_front();
    if (r.en && r.wren) ref_mem[r.addr] = r.data;
    if (!rst_n) model_reset();
    else model_decide(r);
    if (s_rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (s_en && s_wren) mem[s_addr] = s_data;
    pend      = s_en && !s_wren;
    pend_data = (pend && mem.exists(s_addr)) ? mem[s_addr] : '0;
  endtask

  function automatic logic [CL-1:0] rand_line();
    logic [CL-1:0] l;
    for (int i = 0; i < N; i++) l[i*W +: W] = W'($urandom());
    return l;
  endfunction

  initial begin
    logic [CL-1:0] l1, l2, l3, l4;
    model_reset();
    knob_rstn = 1'b0;
    repeat (2) step();
    #1;
    chk("reset DMAEn", CL'(DMAEn), '0);
    chk("reset DMAWrEn", CL'(DMAWrEn), '0);
    chk("reset host_rd_ready", CL'(host_rd_ready), '0);
    chk("reset host_wr_ready", CL'(host_wr_ready), '0);
    chk("reset DMAAddr", CL'(DMAAddr), '0);
    chk("reset data_to_mem", CL'(data_to_mem), '0);
    chk("reset line_buffer", line_buffer, '0);
    knob_rstn = 1'b1;

    // single write: word k = 15-k
    for (int i = 0; i < N; i++) l1[i*W +: W] = W'(15 - i);
    fifo_q.push_back(l1);
    repeat (22) step();
    chk("single write count", CL'(walog.size()), CL'(16));
    for (int i = 0; i < N; i++) begin
      chk("single write data", CL'(wlog[i]), CL'(15 - i));
      chk("single write addr", CL'(walog[i]), CL'(i));
    end

    // readback of that line
    knob_wr = 1'b1;
    step();
    knob_wr = 1'b0;
    repeat (24) step();
    chk("readback count", CL'(ralog.size()), CL'(16));
    for (int i = 0; i < N; i++) chk("readback addr", CL'(ralog[i]), CL'(i));
    chk("readback pushes", CL'(plog.size()), CL'(1));
    chk("readback line", plog[0], l1);

    // priority: write and readback requested together
    for (int i = 0; i < N; i++) l2[i*W +: W] = 32'hA5A5_0000 + W'(i);
    fifo_q.push_back(l2);
    knob_wr = 1'b1;
    repeat (19) step();
    knob_wr = 1'b0;
    repeat (24) step();
    for (int i = 0; i < N; i++) chk("priority write addr", CL'(walog[16 + i]), CL'(16 + i));
    chk("priority pushes", CL'(plog.size()), CL'(2));
    chk("priority line", plog[1], l2);

    // back-to-back lines
    l3 = rand_line();
    l4 = rand_line();
    fifo_q.push_back(l3);
    fifo_q.push_back(l4);
    repeat (40) step();
    chk("b2b write count", CL'(walog.size()), CL'(64));
    for (int i = 0; i < 2 * N; i++) chk("b2b write addr", CL'(walog[32 + i]), CL'(32 + i));

    // backpressure on the push
    knob_full = 1'b1;
    knob_wr = 1'b1;
    step();
    knob_wr = 1'b0;
    repeat (24) step();
    chk("held pushes", CL'(plog.size()), CL'(2));
    knob_full = 1'b0;
    step();
    chk("push after full drop", CL'(plog.size()), CL'(2));
    step();
    chk("push pulse", CL'(plog.size()), CL'(3));
    chk("backpressure line", plog[2], l3);

    // reset in the middle of a line write
    fifo_q.push_back(rand_line());
    repeat (8) step();
    knob_rstn = 1'b0;
    step();
    knob_rstn = 1'b1;
    repeat (5) step();

    repeat (3000) begin
      if (fifo_q.size() < 2 && $urandom_range(15) == 0) fifo_q.push_back(rand_line());
      knob_wr   = ($urandom_range(7) == 0);
      knob_full = ($urandom_range(2) == 0);
      knob_rstn = ($urandom_range(1999) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
